// File: rtl/rate_tick_gen_if.sv
// rate_tick_gen_if: groups the rate select, pause key, tick and run signals of rate_tick_gen
interface rate_tick_gen_if;
    logic [1:0] Sel;
    logic       Key;
    logic       En;
    logic       Run;
    modport master (output Sel, output Key, input En, input Run);
    modport slave  (input Sel, input Key, output En, output Run);
endinterface

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: 1/2/4 Hz tick from Clk with key-toggled pause; ports Clk, R (sync reset), bus.slave {Sel, Key -> En, Run}
module rate_tick_gen #(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = 26
) (
    input logic           Clk,
    input logic           R,
    rate_tick_gen_if.slave bus
);
    logic [CNT_W-1:0] d_q, d_d, tc;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       k_q, k_d;
    logic             en_q, en_d, run_q, run_d, press, same;
    always_comb begin
        tc    = sel_q == 2'd1 ? CNT_W'(CLK_HZ - 1) :
                sel_q == 2'd2 ? CNT_W'(CLK_HZ / 2 - 1) : CNT_W'(CLK_HZ / 4 - 1);
        // k_q = {k3, k2, k1}; a press is the first synchronised low sample
        k_d   = {k_q[1:0], bus.Key};
        press = k_q[2] & ~k_q[1];
        run_d = run_q ^ press;
        sel_d = bus.Sel;
        same  = bus.Sel == sel_q;
        // a rate change or off restarts the period; pause holds the phase
        d_d   = (!same || bus.Sel == 2'd0) ? '0 :
                !run_q ? d_q : d_q == tc ? '0 : d_q + 1'b1;
        en_d  = same && bus.Sel != 2'd0 && run_q && d_q == tc;
    end
    always_ff @(posedge Clk) begin
        if (R) begin
            d_q   <= '0;
            en_q  <= 1'b0;
            run_q <= 1'b1;
            k_q   <= 3'b111;
            sel_q <= bus.Sel;
        end else begin
            d_q   <= d_d;
            en_q  <= en_d;
            run_q <= run_d;
            k_q   <= k_d;
            sel_q <= sel_d;
        end
    end
    assign bus.En  = en_q;
    assign bus.Run = run_q;
endmodule

// File: tb/tb_rate_tick_gen.sv
// tb_rate_tick_gen: randomized check of rate_tick_gen against a period/phase reference model
module tb_rate_tick_gen;
    localparam int CLK_HZ = 8;
    logic Clk = 1'b0;
    logic R = 1'b1;
    int   total = 0;
    int   bad = 0;
    rate_tick_gen_if bus ();
    rate_tick_gen #(.CLK_HZ(CLK_HZ), .CNT_W(4)) dut (.Clk(Clk), .R(R), .bus(bus));
    always #5 Clk = ~Clk;

    // model: elapsed cycles in current period, period length, and key sample history
    int   m_ph = 0;
    int   m_sel = 1;
    bit   m_en = 0;
    bit   m_run = 1;
    bit   s1 = 1, s2 = 1, s3 = 1;

    function automatic int period(int s);
        return CLK_HZ >> (s - 1);
    endfunction

    always @(posedge Clk) begin
        bit press;
        if (R) begin
            m_ph = 0; m_en = 0; m_run = 1; m_sel = int'(bus.Sel);
            s1 = 1; s2 = 1; s3 = 1;
        end else begin
            press = s3 && !s2;
            if (int'(bus.Sel) != m_sel) begin
                m_ph = 0; m_en = 0; m_sel = int'(bus.Sel);
            end else if (m_sel == 0) begin
                m_ph = 0; m_en = 0;
            end else if (!m_run) begin
                m_en = 0;
            end else begin
                m_ph++;
                m_en = m_ph == period(m_sel);
                if (m_en) m_ph = 0;
            end
            if (press) m_run = !m_run;
            s3 = s2; s2 = s1; s1 = bus.Key;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", tag, $time, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk);
            check("en", int'(bus.En), int'(m_en));
            check("run", int'(bus.Run), int'(m_run));
        end
    endtask

    task automatic press_key(input int low);
        bus.Key = 1'b0;
        cyc(low);
        bus.Key = 1'b1;
        cyc(4);
    endtask

    task automatic sel_at_tc(input logic [1:0] nsel);
        int guard = 0;
        while (!(m_sel != 0 && m_run && m_ph == period(m_sel) - 1) && guard < 40) begin
            cyc(1);
            guard++;
        end
        check("tc_wait", int'(guard < 40), 1);
        bus.Sel = nsel;
        cyc(1);
        check("tc_no_tick", int'(bus.En), 0);
    endtask

    initial begin
        bus.Sel = 2'd1;
        bus.Key = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_en", int'(bus.En), 0);
        check("rst_run", int'(bus.Run), 1);
        R = 1'b0;
        cyc(20);
        bus.Sel = 2'd2; cyc(10);
        bus.Sel = 2'd3; cyc(8);
        bus.Sel = 2'd1; cyc(3);
        press_key(5);
        check("paused", int'(bus.Run), 0);
        cyc(12);
        press_key(1);
        check("resumed", int'(bus.Run), 1);
        cyc(10);
        sel_at_tc(2'd2);
        cyc(6);
        bus.Sel = 2'd1; cyc(5);
        press_key(3);
        R = 1'b1; cyc(1);
        R = 1'b0;
        check("rst_run_back", int'(bus.Run), 1);
        cyc(10);
        bus.Sel = 2'd0; cyc(20);
        bus.Sel = 2'd1; cyc(10);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: cyc($urandom_range(1, 20));
                1: begin bus.Sel = 2'($urandom_range(0, 3)); cyc($urandom_range(1, 12)); end
                2: press_key($urandom_range(1, 8));
                3: begin R = 1'b1; cyc($urandom_range(1, 2)); R = 1'b0; cyc($urandom_range(1, 10)); end
                default: if (bus.Sel != 2'd0 && bus.Run) sel_at_tc(2'($urandom_range(0, 3))); else cyc(3);
            endcase
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rate_tick_gen.md
RATE_TICK_GEN -- requirements
Module: rate_tick_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: input clock frequency in Hz; must be a multiple of 4 and at least 4.
REQ-002 SHALL have parameter CNT_W, default 26: divider counter width; must satisfy 2^CNT_W > CLK_HZ-1.
REQ-003 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port R, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Sel, input, 2: rate select; 00 = off, 01 = 1 Hz, 10 = 2 Hz, 11 = 4 Hz.
REQ-006 SHALL have port Key, input, 1: active-low pushbutton that toggles pause; it is asynchronous to Clk.
REQ-007 SHALL have port En, output, 1: registered one-cycle tick pulse that drives the downstream counter's enable.
REQ-008 SHALL have port Run, output, 1: registered run/pause state; 1 = running.

Function
REQ-009 SHALL define terminal count TC as CLK_HZ-1 for Sel=01, CLK_HZ/2-1 for Sel=10 and CLK_HZ/4-1 for Sel=11.
REQ-010 SHALL keep an internal CNT_W-bit divider D and a registered copy Sel_q of Sel.
REQ-011 SHALL, each cycle with Run=1, Sel=Sel_q and Sel!=00, set D to 0 and En to 1 when D==TC; otherwise D increments and En is 0.
REQ-012 SHALL hold D and drive En=0 while Run=0 (pause keeps phase; resume continues from held D).
REQ-013 SHALL drive En=0 and hold D at 0 while Sel=00.
REQ-014 SHALL, on any cycle with Sel!=Sel_q, set D to 0, set En to 0 and load Sel_q with Sel; a rate change therefore restarts a full period and suppresses a coincident terminal-count tick.
REQ-015 SHALL never assert En for two consecutive cycles unless TC=0; with CLK_HZ>=4 and Sel=11, TC>=0 and the minimum period is CLK_HZ/4 cycles.
REQ-016 SHALL synchronise Key through two flip-flops (k1, k2) followed by an edge register k3, and detect a press as k3=1 and k2=0.
REQ-017 SHALL toggle Run on the third rising Clk edge at which Key is sampled low, counting the first low sample as edge 1; each press gives exactly one toggle, and holding Key low gives no further toggles.
REQ-018 SHALL base the En decision on Run's value before the toggle when a press toggle and a terminal count coincide; the toggle takes effect from the next cycle.
REQ-019 SHALL apply no debounce filtering beyond synchronisation; the bench drives clean edges.

Reset
REQ-020 SHALL, on a rising Clk with R=1, set D=0, En=0, Run=1, k1=k2=k3=1 and Sel_q=Sel; R overrides all other inputs.
REQ-021 SHALL abandon a partial period when reset is asserted mid-period; after R is released, the first tick occurs a full TC+1 cycles later.

Verification (CLK_HZ=8, CNT_W=4)
REQ-022 SHALL check: R pulsed, Sel=01 held, Key=1 -> En high for exactly one cycle after the 8th rising edge after R is released, then every 8 cycles; Run=1 throughout.
REQ-023 SHALL check: Sel=10, then Sel=11 -> En period 4 cycles, then 2 cycles; the switch cycle restarts D, and the first tick at the new rate comes 2 cycles after Sel_q updates.
REQ-024 SHALL check: Key driven low for 5 cycles during Sel=01 -> Run falls on the 3rd edge; En stays 0 for the whole pause and D holds; a second press sets Run=1 and the next tick completes the interrupted period.
REQ-025 SHALL check: Sel changed on the exact cycle D==TC -> no En pulse on that cycle, and D=0 afterwards.
REQ-026 SHALL check: R asserted with D=5 and Run=0 -> next cycle D=0, En=0, Run=1, then a normal 8-cycle period.
REQ-027 SHALL check: Sel=00 for 20 cycles -> En never asserts; returning to Sel=01 gives the first tick 8 cycles after Sel_q updates.
